// File: rtl/key_entry_ctrl.sv
// rtl/key_entry_ctrl.sv - keypad key debouncer and BCD operand entry controller
// One event per debounced press; digits shift into a BCD buffer, operators latch it.
module key_entry_ctrl #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int NDIGITS         = 4
) (
    input  logic                   CLK,
    input  logic                   RESET,
    input  logic [3:0]             BCDKey,
    input  logic                   KeyRead,
    output logic [4*NDIGITS-1:0]   Digits,
    output logic [2:0]             DigitCount,
    output logic [4*NDIGITS-1:0]   Operand,
    output logic [3:0]             OpCode,
    output logic                   OpValid,
    output logic                   KeyStrobe,
    output logic                   Overflow,
    output logic                   ClearPulse
);

    localparam int         W       = 4 * NDIGITS;
    localparam logic [7:0] DB_LAST = 8'(DEBOUNCE_CYCLES - 1);
    localparam logic [2:0] NDIG    = 3'(NDIGITS);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DEBOUNCE = 2'd1,
        PRESSED  = 2'd2,
        RELEASE  = 2'd3
    } state_t;

    state_t         state_q, state_d;
    logic [7:0]     cnt_q, cnt_d;
    logic [3:0]     code_q, code_d;
    logic [W-1:0]   digits_q, digits_d;
    logic [2:0]     count_q, count_d;
    logic [W-1:0]   operand_q, operand_d;
    logic [3:0]     opcode_q, opcode_d;
    logic           opvalid_q, opvalid_d;
    logic           strobe_q, strobe_d;
    logic           overflow_q, overflow_d;
    logic           clear_q, clear_d;
    logic           accept;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            code_q     <= '0;
            digits_q   <= '0;
            count_q    <= '0;
            operand_q  <= '0;
            opcode_q   <= '0;
            opvalid_q  <= 1'b0;
            strobe_q   <= 1'b0;
            overflow_q <= 1'b0;
            clear_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            code_q     <= code_d;
            digits_q   <= digits_d;
            count_q    <= count_d;
            operand_q  <= operand_d;
            opcode_q   <= opcode_d;
            opvalid_q  <= opvalid_d;
            strobe_q   <= strobe_d;
            overflow_q <= overflow_d;
            clear_q    <= clear_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        code_d     = code_q;
        digits_d   = digits_q;
        count_d    = count_q;
        operand_d  = operand_q;
        opcode_d   = opcode_q;
        opvalid_d  = 1'b0;
        strobe_d   = 1'b0;
        overflow_d = 1'b0;
        clear_d    = 1'b0;
        accept     = 1'b0;

        case (state_q)
            IDLE: begin
                if (KeyRead) begin
                    code_d  = BCDKey;
                    cnt_d   = 8'd1;
                    state_d = DEBOUNCE;
                end
            end
            DEBOUNCE: begin
                // A mismatching sample is consumed here; capture restarts from IDLE.
                if (!KeyRead || (BCDKey != code_q)) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end else if (cnt_q == DB_LAST) begin
                    cnt_d   = '0;
                    accept  = 1'b1;
                    state_d = PRESSED;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            PRESSED: begin
                if (!KeyRead) begin
                    cnt_d   = 8'd1;
                    state_d = RELEASE;
                end
            end
            RELEASE: begin
                if (KeyRead) begin
                    cnt_d   = '0;
                    state_d = PRESSED;
                end else if (cnt_q == DB_LAST) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase

        if (accept) begin
            strobe_d = 1'b1;
            if (code_q < 4'd10) begin
                if (count_q < NDIG) begin
                    digits_d = W'({digits_q, code_q});
                    count_d  = count_q + 3'd1;
                end else begin
                    overflow_d = 1'b1;
                end
            end else if (code_q < 4'd15) begin
                operand_d = digits_q;
                opcode_d  = code_q;
                opvalid_d = 1'b1;
                digits_d  = '0;
                count_d   = '0;
            end else begin
                digits_d = '0;
                count_d  = '0;
                clear_d  = 1'b1;
            end
        end
    end

    assign Digits     = digits_q;
    assign DigitCount = count_q;
    assign Operand    = operand_q;
    assign OpCode     = opcode_q;
    assign OpValid    = opvalid_q;
    assign KeyStrobe  = strobe_q;
    assign Overflow   = overflow_q;
    assign ClearPulse = clear_q;

endmodule

// File: tb/tb_key_entry_ctrl.sv
// tb/tb_key_entry_ctrl.sv - scoreboard bench for key_entry_ctrl
module tb_key_entry_ctrl;

    localparam int DB = 4;

    logic        CLK = 1'b0;
    logic        RESET;
    logic [3:0]  BCDKey;
    logic        KeyRead;
    logic [15:0] Digits;
    logic [2:0]  DigitCount;
    logic [15:0] Operand;
    logic [3:0]  OpCode;
    logic        OpValid;
    logic        KeyStrobe;
    logic        Overflow;
    logic        ClearPulse;

    key_entry_ctrl #(.DEBOUNCE_CYCLES(DB), .NDIGITS(4)) dut (
        .CLK        (CLK),
        .RESET      (RESET),
        .BCDKey     (BCDKey),
        .KeyRead    (KeyRead),
        .Digits     (Digits),
        .DigitCount (DigitCount),
        .Operand    (Operand),
        .OpCode     (OpCode),
        .OpValid    (OpValid),
        .KeyStrobe  (KeyStrobe),
        .Overflow   (Overflow),
        .ClearPulse (ClearPulse)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    typedef struct {
        int          at;
        logic [15:0] digits;
        logic [2:0]  count;
        logic [15:0] operand;
        logic [3:0]  opcode;
        logic        opv;
        logic        ovf;
        logic        clr;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    logic [15:0] m_digits  = '0;
    logic [2:0]  m_count   = '0;
    logic [15:0] m_operand = '0;
    logic [3:0]  m_opcode  = '0;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic expect_press(input logic [3:0] c, input int at);
        exp_t e;
        e.at = at;
        e.opv = 1'b0;
        e.ovf = 1'b0;
        e.clr = 1'b0;
        if (c < 4'd10) begin
            if (m_count < 3'd4) begin
                m_digits = {m_digits[11:0], c};
                m_count  = m_count + 3'd1;
            end else begin
                e.ovf = 1'b1;
            end
        end else if (c < 4'd15) begin
            m_operand = m_digits;
            m_opcode  = c;
            m_digits  = '0;
            m_count   = '0;
            e.opv     = 1'b1;
        end else begin
            m_digits = '0;
            m_count  = '0;
            e.clr    = 1'b1;
        end
        e.digits  = m_digits;
        e.count   = m_count;
        e.operand = m_operand;
        e.opcode  = m_opcode;
        sb.push_back(e);
    endtask

    task automatic press(input logic [3:0] c);
        @(negedge CLK);
        BCDKey  = c;
        KeyRead = 1'b1;
        expect_press(c, cyc + DB);
        repeat (DB + 2) @(negedge CLK);
        KeyRead = 1'b0;
        repeat (DB + 2) @(negedge CLK);
    endtask

    task automatic check_zero(input string tag);
        check(tag, {Digits, DigitCount, Operand, OpCode, OpValid, KeyStrobe, Overflow, ClearPulse}, 64'd0);
    endtask

    task automatic model_reset();
        m_digits  = '0;
        m_count   = '0;
        m_operand = '0;
        m_opcode  = '0;
    endtask

    always @(negedge CLK) begin
        if (!RESET) begin
            if (KeyStrobe) begin
                if (sb.size() == 0) begin
                    check("unexpected_strobe", 64'd1, 64'd0);
                end else begin
                    mon_e = sb.pop_front();
                    check("strobe_cycle", 64'(cyc), 64'(mon_e.at));
                    check("digits", 64'(Digits), 64'(mon_e.digits));
                    check("digit_count", 64'(DigitCount), 64'(mon_e.count));
                    check("operand", 64'(Operand), 64'(mon_e.operand));
                    check("opcode", 64'(OpCode), 64'(mon_e.opcode));
                    check("opvalid", 64'(OpValid), 64'(mon_e.opv));
                    check("overflow", 64'(Overflow), 64'(mon_e.ovf));
                    check("clearpulse", 64'(ClearPulse), 64'(mon_e.clr));
                end
            end else if (OpValid || Overflow || ClearPulse) begin
                check("stray_pulse", {61'd0, OpValid, Overflow, ClearPulse}, 64'd0);
            end
        end
    end

    initial begin
        logic [9:0] bounce;
        RESET   = 1'b1;
        KeyRead = 1'b0;
        BCDKey  = 4'd0;
        repeat (3) @(negedge CLK);
        check_zero("reset_state");
        RESET = 1'b0;

        press(4'd7);
        check("single_digit", 64'(Digits), 64'h0007);

        // Glitchy press never reaches DEBOUNCE_CYCLES matching samples.
        @(negedge CLK);
        BCDKey = 4'd9;
        KeyRead = 1'b1;
        repeat (3) @(negedge CLK);
        KeyRead = 1'b0;
        @(negedge CLK);
        KeyRead = 1'b1;
        repeat (3) @(negedge CLK);
        KeyRead = 1'b0;
        repeat (DB + 2) @(negedge CLK);
        check("glitch_digits", 64'(Digits), 64'(m_digits));
        press(4'd15);

        // Code change: the first 6 sample aborts, the next one restarts debounce.
        @(negedge CLK);
        BCDKey  = 4'd5;
        KeyRead = 1'b1;
        repeat (2) @(negedge CLK);
        BCDKey = 4'd6;
        expect_press(4'd6, cyc + DB + 1);
        repeat (DB + 3) @(negedge CLK);
        KeyRead = 1'b0;
        repeat (DB + 2) @(negedge CLK);
        check("code_change_digits", 64'(Digits), 64'h0006);
        press(4'd15);

        // Release bounce; the following press checks IDLE was reached on time.
        @(negedge CLK);
        BCDKey  = 4'd3;
        KeyRead = 1'b1;
        expect_press(4'd3, cyc + DB);
        repeat (DB + 2) @(negedge CLK);
        bounce = 10'b0000110010;
        for (int i = 9; i >= 0; i--) begin
            KeyRead = bounce[i];
            @(negedge CLK);
        end
        check("bounce_digits", 64'(Digits), 64'h0003);
        press(4'd15);

        for (int d = 1; d <= 5; d++) press(4'(d));
        check("full_digits", 64'(Digits), 64'h1234);
        check("full_count", 64'(DigitCount), 64'd4);
        press(4'd15);

        press(4'd4);
        press(4'd2);
        press(4'd12);
        check("op_operand", 64'(Operand), 64'h0042);
        press(4'd15);
        check("clear_keeps_operand", 64'(Operand), 64'h0042);

        // Async reset mid-debounce.
        @(negedge CLK);
        BCDKey  = 4'd2;
        KeyRead = 1'b1;
        repeat (2) @(negedge CLK);
        #2 RESET = 1'b1;
        #1 check_zero("reset_mid_debounce");
        model_reset();
        KeyRead = 1'b0;
        repeat (2) @(negedge CLK);
        RESET = 1'b0;
        repeat (DB + 2) @(negedge CLK);

        // Async reset while held in PRESSED.
        @(negedge CLK);
        BCDKey  = 4'd9;
        KeyRead = 1'b1;
        expect_press(4'd9, cyc + DB);
        repeat (DB + 2) @(negedge CLK);
        check("pressed_digits", 64'(Digits), 64'h0009);
        #2 RESET = 1'b1;
        #1 check_zero("reset_in_pressed");
        model_reset();
        KeyRead = 1'b0;
        repeat (2) @(negedge CLK);
        RESET = 1'b0;
        repeat (DB + 2) @(negedge CLK);

        press(4'd8);
        check("after_reset_digits", 64'(Digits), 64'h0008);
        check("after_reset_count", 64'(DigitCount), 64'd1);

        repeat (4) @(negedge CLK);
        check("scoreboard_drained", 64'(sb.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
